// File: rtl/fetch_unit_if.sv
// Bundle of the fetch unit's program-memory read port, branch redirect and
// downstream instruction handshake.
interface fetch_unit_if;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata;
    logic       branch_valid;
    logic [7:0] branch_target;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr_opcode;
    logic [7:0] instr_operand;
    logic [7:0] instr_pc;
    logic       halted;

    modport master (
        output mem_addr,
        input  mem_rdata,
        input  branch_valid,
        input  branch_target,
        output instr_valid,
        input  instr_ready,
        output instr_opcode,
        output instr_operand,
        output instr_pc,
        output halted
    );

    modport slave (
        input  mem_addr,
        output mem_rdata,
        output branch_valid,
        output branch_target,
        input  instr_valid,
        output instr_ready,
        input  instr_opcode,
        input  instr_operand,
        input  instr_pc,
        input  halted
    );
endinterface

// File: rtl/fetch_unit.sv
// Byte-serial instruction fetch: reads one- or two-byte instructions from a
// 256x8 program memory and offers them downstream through a valid/ready hold.
module fetch_unit (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    typedef enum logic [1:0] {
        FETCH_OP  = 2'd0,
        FETCH_ARG = 2'd1,
        HOLD      = 2'd2,
        HALTED    = 2'd3
    } state_t;

    localparam logic [7:0] HALT_OP = 8'hFF;

    state_t     state;
    logic [7:0] pc;

    // Bit 7 selects a two-byte instruction, except HALT which is always one byte.
    function automatic logic is_two_byte(input logic [7:0] op);
        return op[7] && (op != HALT_OP);
    endfunction

    assign bus.mem_addr = pc;

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // branch of the case reads the pre-edge values of pc and instr_opcode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= FETCH_OP;
            pc                <= 8'h00;
            bus.instr_valid   <= 1'b0;
            bus.instr_opcode  <= 8'h00;
            bus.instr_operand <= 8'h00;
            bus.instr_pc      <= 8'h00;
            bus.halted        <= 1'b0;
        end else if (bus.branch_valid) begin
            // A redirect drops any partial or held instruction, even one being accepted.
            state           <= FETCH_OP;
            pc              <= bus.branch_target;
            bus.instr_valid <= 1'b0;
            bus.halted      <= 1'b0;
        end else begin
            case (state)
                FETCH_OP: begin
                    bus.instr_opcode <= bus.mem_rdata;
                    bus.instr_pc     <= pc;
                    pc               <= pc + 8'd1;
                    if (is_two_byte(bus.mem_rdata)) begin
                        state <= FETCH_ARG;
                    end else begin
                        bus.instr_operand <= 8'h00;
                        bus.instr_valid   <= 1'b1;
                        state             <= HOLD;
                    end
                end
                FETCH_ARG: begin
                    bus.instr_operand <= bus.mem_rdata;
                    pc                <= pc + 8'd1;
                    bus.instr_valid   <= 1'b1;
                    state             <= HOLD;
                end
                HOLD: begin
                    if (bus.instr_ready) begin
                        bus.instr_valid <= 1'b0;
                        if (bus.instr_opcode == HALT_OP) begin
                            bus.halted <= 1'b1;
                            state      <= HALTED;
                        end else begin
                            state <= FETCH_OP;
                        end
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state <= FETCH_OP;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a transaction-level fetch model is compared
// every cycle, and literal expectations pin each scenario.
module tb_fetch_unit;
    logic       clk;
    logic       rst;
    logic [7:0] mem [256];

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    assign bus.mem_rdata = mem[bus.mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction length straight from the opcode rules.
    function automatic logic [7:0] ilen(input logic [7:0] op);
        return (op[7] && op != 8'hFF) ? 8'd2 : 8'd1;
    endfunction

    // Model: an instruction starting at m_start is fetched one byte per cycle;
    // once all its bytes are in, the whole bundle is offered until accepted.
    logic [7:0] m_start, m_done, m_op, m_arg, m_pc;
    bit         m_offer, m_halt;

    always @(posedge clk) begin
        if (rst) begin
            m_start = 8'h00; m_done = 8'h00; m_offer = 1'b0; m_halt = 1'b0;
        end else if (bus.branch_valid) begin
            m_start = bus.branch_target; m_done = 8'h00; m_offer = 1'b0; m_halt = 1'b0;
        end else if (m_halt) begin
            m_done = m_done;
        end else if (m_offer) begin
            if (bus.instr_ready) begin
                m_offer = 1'b0;
                if (m_op == 8'hFF) m_halt = 1'b1;
                m_start = m_start + ilen(m_op);
                m_done  = 8'h00;
            end
        end else begin
            m_done = m_done + 8'd1;
            if (m_done == ilen(mem[m_start])) begin
                m_offer = 1'b1;
                m_op    = mem[m_start];
                m_arg   = (m_done == 8'd2) ? mem[8'(m_start + 8'd1)] : 8'h00;
                m_pc    = m_start;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_valid", bus.instr_valid, m_offer);
            check("model_halted", bus.halted, m_halt);
            check("model_mem_addr", bus.mem_addr, 8'(m_start + m_done));
            if (m_offer) begin
                check("model_opcode", bus.instr_opcode, m_op);
                check("model_operand", bus.instr_operand, m_arg);
                check("model_pc", bus.instr_pc, m_pc);
            end
        end
    end

    task automatic start_test();
        @(negedge clk);
        rst               = 1'b1;
        bus.branch_valid  = 1'b0;
        bus.branch_target = 8'h00;
        bus.instr_ready   = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    // Leaves the bench at the sampling point of cycle 0 (first FETCH_OP cycle).
    task automatic release_reset();
        @(negedge clk);
        check("rst_valid", bus.instr_valid, 1'b0);
        check("rst_opcode", bus.instr_opcode, 8'h00);
        check("rst_operand", bus.instr_operand, 8'h00);
        check("rst_pc", bus.instr_pc, 8'h00);
        check("rst_halted", bus.halted, 1'b0);
        check("rst_mem_addr", bus.mem_addr, 8'h00);
        rst    = 1'b0;
        chk_en = 1'b1;
    endtask

    task automatic expect_bundle(input string name, input logic [7:0] op,
                                 input logic [7:0] arg, input logic [7:0] pc);
        check({name, "_valid"}, bus.instr_valid, 1'b1);
        check({name, "_opcode"}, bus.instr_opcode, op);
        check({name, "_operand"}, bus.instr_operand, arg);
        check({name, "_pc"}, bus.instr_pc, pc);
    endtask

    initial begin
        rst               = 1'b1;
        bus.branch_valid  = 1'b0;
        bus.branch_target = 8'h00;
        bus.instr_ready   = 1'b1;

        // One-byte pair, ready held high.
        start_test();
        mem[0] = 8'h12; mem[1] = 8'h34;
        release_reset();
        @(negedge clk); expect_bundle("t1_b0", 8'h12, 8'h00, 8'h00);
        @(negedge clk); check("t1_gap_valid", bus.instr_valid, 1'b0);
        check("t1_gap_addr", bus.mem_addr, 8'h01);
        @(negedge clk); expect_bundle("t1_b1", 8'h34, 8'h00, 8'h01);

        // Two-byte instruction latency.
        start_test();
        mem[0] = 8'h85; mem[1] = 8'hAA; mem[2] = 8'h01;
        release_reset();
        @(negedge clk); check("t2_arg_valid", bus.instr_valid, 1'b0);
        check("t2_arg_addr", bus.mem_addr, 8'h01);
        @(negedge clk); expect_bundle("t2_b0", 8'h85, 8'hAA, 8'h00);
        @(negedge clk); check("t2_next_addr", bus.mem_addr, 8'h02);

        // Branch to FF, operand fetched across the wrap.
        start_test();
        mem[8'hFF] = 8'h90; mem[0] = 8'h07;
        release_reset();
        bus.branch_valid = 1'b1; bus.branch_target = 8'hFF;
        @(negedge clk); bus.branch_valid = 1'b0;
        check("t3_br_addr", bus.mem_addr, 8'hFF);
        check("t3_br_valid", bus.instr_valid, 1'b0);
        @(negedge clk); check("t3_wrap_addr", bus.mem_addr, 8'h00);
        @(negedge clk); expect_bundle("t3_b0", 8'h90, 8'h07, 8'hFF);
        check("t3_pc_after", bus.mem_addr, 8'h01);

        // Backpressure: 5 stalled cycles, then exactly one transfer.
        start_test();
        mem[0] = 8'h12;
        bus.instr_ready = 1'b0;
        release_reset();
        @(negedge clk); expect_bundle("t4_offer", 8'h12, 8'h00, 8'h00);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); expect_bundle("t4_stall", 8'h12, 8'h00, 8'h00);
            check("t4_stall_addr", bus.mem_addr, 8'h01);
        end
        bus.instr_ready = 1'b1;
        @(negedge clk); bus.instr_ready = 1'b0;
        check("t4_xfer_valid", bus.instr_valid, 1'b0);
        check("t4_xfer_addr", bus.mem_addr, 8'h01);
        @(negedge clk); expect_bundle("t4_next", 8'h00, 8'h00, 8'h01);
        repeat (2) @(negedge clk);
        check("t4_next_held_addr", bus.mem_addr, 8'h02);
        bus.instr_ready = 1'b1;

        // HALT at address 03, then wake by branch.
        start_test();
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'hFF;
        release_reset();
        repeat (7) @(negedge clk);
        expect_bundle("t5_halt_offer", 8'hFF, 8'h00, 8'h03);
        @(negedge clk); check("t5_halted", bus.halted, 1'b1);
        check("t5_halt_valid", bus.instr_valid, 1'b0);
        check("t5_halt_addr", bus.mem_addr, 8'h04);
        repeat (3) @(negedge clk);
        check("t5_frozen_addr", bus.mem_addr, 8'h04);
        check("t5_still_halted", bus.halted, 1'b1);
        bus.branch_valid = 1'b1; bus.branch_target = 8'h10;
        @(negedge clk); bus.branch_valid = 1'b0;
        check("t5_wake_halted", bus.halted, 1'b0);
        check("t5_wake_addr", bus.mem_addr, 8'h10);

        // Reset beats a simultaneous branch while mid-FETCH_ARG.
        start_test();
        mem[0] = 8'h85; mem[1] = 8'hAA;
        release_reset();
        @(negedge clk); check("t6_in_arg_addr", bus.mem_addr, 8'h01);
        rst = 1'b1; bus.branch_valid = 1'b1; bus.branch_target = 8'h55;
        release_reset();
        bus.branch_valid = 1'b0;

        // Branch while a held bundle is being accepted.
        start_test();
        mem[0] = 8'h12; mem[8'h40] = 8'h21;
        release_reset();
        @(negedge clk); expect_bundle("t7_offer", 8'h12, 8'h00, 8'h00);
        bus.branch_valid = 1'b1; bus.branch_target = 8'h40;
        @(negedge clk); bus.branch_valid = 1'b0;
        check("t7_br_valid", bus.instr_valid, 1'b0);
        check("t7_br_addr", bus.mem_addr, 8'h40);
        @(negedge clk); expect_bundle("t7_target", 8'h21, 8'h00, 8'h40);
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
